// File: rtl/fetch_pkg.sv
// Shared opcode classification constants and helper for the fetch/issue path.
package fetch_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    S1   = 2'd1,
    S1S2 = 2'd2
  } op_class_e;

  localparam int unsigned CLASS_OPS = 8;

  localparam logic [4:0] S1_OPS [CLASS_OPS] = '{
    5'b00001, 5'b00110, 5'b00111, 5'b01000,
    5'b01001, 5'b01010, 5'b01011, 5'b11011
  };

  localparam logic [4:0] S1S2_OPS [CLASS_OPS] = '{
    5'b00010, 5'b00011, 5'b00100, 5'b00101,
    5'b11000, 5'b11010, 5'b11100, 5'b11110
  };

  function automatic op_class_e classify5(input logic [4:0] op);
    op_class_e cls;
    cls = NONE;
    for (int unsigned i = 0; i < CLASS_OPS; i++) begin
      if (op == S1_OPS[i])   cls = S1;
      if (op == S1S2_OPS[i]) cls = S1S2;
    end
    return cls;
  endfunction

endpackage

// File: rtl/operand_mask.sv
// Combinational opcode classification and source-operand masking.
module operand_mask
  import fetch_pkg::*;
#(
  parameter int unsigned OPW = 5,
  parameter int unsigned RAW = 4
) (
  input  logic [OPW-1:0] opcode,
  input  logic [RAW-1:0] s1,
  input  logic [RAW-1:0] s2,
  output logic [RAW-1:0] s1_masked,
  output logic [RAW-1:0] s2_masked,
  output logic           s1_used,
  output logic           s2_used
);

  logic      upper_zero;
  op_class_e cls;

  // Wider opcodes only classify when the bits above the 5-bit table are clear.
  if (OPW > 5) begin : g_wide
    assign upper_zero = (opcode[OPW-1:5] == '0);
  end else begin : g_narrow
    assign upper_zero = 1'b1;
  end

  // Classify the opcode and zero any operand the instruction does not read.
  always_comb begin
    cls       = upper_zero ? classify5(opcode[4:0]) : NONE;
    s1_used   = 1'b0;
    s2_used   = 1'b0;
    s1_masked = '0;
    s2_masked = '0;
    case (cls)
      S1: begin
        s1_used   = 1'b1;
        s1_masked = s1;
      end
      S1S2: begin
        s1_used   = 1'b1;
        s2_used   = 1'b1;
        s1_masked = s1;
        s2_masked = s2;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fetch_issue_buffer.sv
// Two-entry fetch/issue FIFO with operand masking applied on the input side.
module fetch_issue_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned OPW = 5,
  parameter int unsigned RAW = 4,
  parameter int unsigned IMW = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] opcode_in,
  input  logic [RAW-1:0] s1_in,
  input  logic [RAW-1:0] s2_in,
  input  logic [RAW-1:0] dest_in,
  input  logic [IMW-1:0] ime_data_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [OPW-1:0] opcode_out,
  output logic [RAW-1:0] s1_out,
  output logic [RAW-1:0] s2_out,
  output logic [RAW-1:0] dest_out,
  output logic [IMW-1:0] ime_data_out,
  output logic           s1_used,
  output logic           s2_used,
  output logic [1:0]     occupancy
);

  logic [RAW-1:0] s1_masked, s2_masked;
  logic           s1_used_in, s2_used_in;

  logic [1:0]     count_q;
  logic           rd_ptr_q, wr_ptr_q;
  logic           accept, deliver;

  logic [OPW-1:0] opc_q  [2];
  logic [RAW-1:0] s1_q   [2];
  logic [RAW-1:0] s2_q   [2];
  logic [RAW-1:0] dest_q [2];
  logic [IMW-1:0] ime_q  [2];
  logic [1:0]     used_q [2];

  operand_mask #(
    .OPW(OPW),
    .RAW(RAW)
  ) u_operand_mask (
    .opcode    (opcode_in),
    .s1        (s1_in),
    .s2        (s2_in),
    .s1_masked (s1_masked),
    .s2_masked (s2_masked),
    .s1_used   (s1_used_in),
    .s2_used   (s2_used_in)
  );

  // Handshake qualifiers; flush overrides both directions.
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign occupancy = count_q;
  assign accept    = in_valid & in_ready & ~flush;
  assign deliver   = out_valid & out_ready & ~flush;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else if (flush) begin
      count_q  <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      if (accept)  wr_ptr_q <= ~wr_ptr_q;
      if (deliver) rd_ptr_q <= ~rd_ptr_q;
      case ({accept, deliver})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage; contents are don't-care while the slot is not occupied.
  always_ff @(posedge clk) begin
    if (accept) begin
      opc_q[wr_ptr_q]  <= opcode_in;
      s1_q[wr_ptr_q]   <= s1_masked;
      s2_q[wr_ptr_q]   <= s2_masked;
      dest_q[wr_ptr_q] <= dest_in;
      ime_q[wr_ptr_q]  <= ime_data_in;
      used_q[wr_ptr_q] <= {s2_used_in, s1_used_in};
    end
  end

  // Present the head entry, or all zeros when the buffer is empty.
  always_comb begin
    opcode_out   = '0;
    s1_out       = '0;
    s2_out       = '0;
    dest_out     = '0;
    ime_data_out = '0;
    s1_used      = 1'b0;
    s2_used      = 1'b0;
    if (out_valid) begin
      opcode_out   = opc_q[rd_ptr_q];
      s1_out       = s1_q[rd_ptr_q];
      s2_out       = s2_q[rd_ptr_q];
      dest_out     = dest_q[rd_ptr_q];
      ime_data_out = ime_q[rd_ptr_q];
      s1_used      = used_q[rd_ptr_q][0];
      s2_used      = used_q[rd_ptr_q][1];
    end
  end

endmodule

// File: tb/tb_fetch_issue_buffer.sv
// Self-checking bench: queue-based reference model plus directed literal checks.
module tb_fetch_issue_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  opcode_in = '0;
  logic [3:0]  s1_in = '0, s2_in = '0, dest_in = '0;
  logic [31:0] ime_data_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  opcode_out;
  logic [3:0]  s1_out, s2_out, dest_out;
  logic [31:0] ime_data_out;
  logic        s1_used, s2_used;
  logic [1:0]  occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [4:0]  op;
    logic [3:0]  s1, s2, d;
    logic [31:0] ime;
    logic        u1, u2;
  } ent_t;

  ent_t       mq[$];
  ent_t       exp_h;
  logic [4:0] dlog[$];

  fetch_issue_buffer #(.OPW(5), .RAW(4), .IMW(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode_in(opcode_in), .s1_in(s1_in), .s2_in(s2_in),
    .dest_in(dest_in), .ime_data_in(ime_data_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .opcode_out(opcode_out), .s1_out(s1_out), .s2_out(s2_out),
    .dest_out(dest_out), .ime_data_out(ime_data_out),
    .s1_used(s1_used), .s2_used(s2_used), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic ent_t make_ent(input logic [4:0] op, input logic [3:0] s1,
                                    input logic [3:0] s2, input logic [3:0] d,
                                    input logic [31:0] ime);
    ent_t e;
    e.op = op; e.d = d; e.ime = ime;
    e.s1 = '0; e.s2 = '0; e.u1 = 1'b0; e.u2 = 1'b0;
    if (op inside {5'd1, [5'd6:5'd11], 5'd27}) begin
      e.s1 = s1; e.u1 = 1'b1;
    end else if (op inside {[5'd2:5'd5], 5'd24, 5'd26, 5'd28, 5'd30}) begin
      e.s1 = s1; e.s2 = s2; e.u1 = 1'b1; e.u2 = 1'b1;
    end
    return e;
  endfunction

  // Reference model: ordered queue of at most two entries.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
    end else if (flush) begin
      mq.delete();
    end else begin
      automatic int  n   = mq.size();
      automatic bit  acc = in_valid && (n < 2);
      automatic bit  del = out_ready && (n > 0);
      automatic ent_t e  = make_ent(opcode_in, s1_in, s2_in, dest_in, ime_data_in);
      if (del) void'(mq.pop_front());
      if (acc) mq.push_back(e);
    end
  end

  // Log of opcodes actually handed downstream.
  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready && !flush) dlog.push_back(opcode_out);
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (mq.size() > 0) exp_h = mq[0];
    else exp_h = make_ent(5'd0, 4'd0, 4'd0, 4'd0, 32'd0);
    chk("m_occupancy", occupancy, mq.size());
    chk("m_in_ready",  in_ready,  mq.size() < 2);
    chk("m_out_valid", out_valid, mq.size() > 0);
    chk("m_opcode",    opcode_out,   exp_h.op);
    chk("m_s1",        s1_out,       exp_h.s1);
    chk("m_s2",        s2_out,       exp_h.s2);
    chk("m_dest",      dest_out,     exp_h.d);
    chk("m_ime",       ime_data_out, exp_h.ime);
    chk("m_s1_used",   s1_used,      exp_h.u1);
    chk("m_s2_used",   s2_used,      exp_h.u2);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [4:0] op, input logic [3:0] s1,
                       input logic [3:0] s2, input logic [3:0] d, input logic [31:0] ime);
    in_valid = v; opcode_in = op; s1_in = s1; s2_in = s2; dest_in = d; ime_data_in = ime;
  endtask

  task automatic drain(input int cycles);
    out_ready = 1'b1;
    repeat (cycles) step();
    out_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_occupancy", occupancy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_opcode",    opcode_out, 0);
    step(); step();
    rst_n = 1'b1;

    // s1-only opcode
    step(); drive(1, 5'b00001, 4'd3, 4'd7, 4'd1, 32'h11);
    step(); in_valid = 1'b0;
    @(negedge clk);
    chk("t1_out_valid", out_valid, 1);
    chk("t1_s1", s1_out, 3);
    chk("t1_s2", s2_out, 0);
    chk("t1_s1_used", s1_used, 1);
    chk("t1_s2_used", s2_used, 0);
    step(); drain(1);

    // dual-operand opcode, passthrough fields
    drive(1, 5'b11100, 4'd2, 4'd5, 4'd9, 32'hDEADBEEF);
    step(); in_valid = 1'b0;
    @(negedge clk);
    chk("t2_opcode", opcode_out, 5'b11100);
    chk("t2_s1", s1_out, 2);
    chk("t2_s2", s2_out, 5);
    chk("t2_dest", dest_out, 9);
    chk("t2_ime", ime_data_out, 32'hDEADBEEF);
    chk("t2_used", {s1_used, s2_used}, 2'b11);
    step(); drain(1);

    // unclassified opcode
    drive(1, 5'b10001, 4'd4, 4'd6, 4'd2, 32'h1234);
    step(); in_valid = 1'b0;
    @(negedge clk);
    chk("t3_s1", s1_out, 0);
    chk("t3_s2", s2_out, 0);
    chk("t3_used", {s1_used, s2_used}, 2'b00);
    step(); drain(1);

    // back-pressure: A, B, C with C stalled until space frees
    dlog.delete();
    drive(1, 5'd2, 4'd1, 4'd2, 4'd3, 32'hA);
    step(); drive(1, 5'd3, 4'd4, 4'd5, 4'd6, 32'hB);
    step(); drive(1, 5'd4, 4'd7, 4'd8, 4'd9, 32'hC);
    step();
    @(negedge clk);
    chk("t4_occupancy", occupancy, 2);
    chk("t4_in_ready", in_ready, 0);
    chk("t4_head", opcode_out, 5'd2);
    step(); out_ready = 1'b1;
    step(); step(); in_valid = 1'b0;
    step(); step(); out_ready = 1'b0;
    chk("t4_count", dlog.size(), 3);
    chk("t4_order0", dlog.size() > 0 ? dlog[0] : 5'h1f, 5'd2);
    chk("t4_order1", dlog.size() > 1 ? dlog[1] : 5'h1f, 5'd3);
    chk("t4_order2", dlog.size() > 2 ? dlog[2] : 5'h1f, 5'd4);

    // flush while full with input offered
    dlog.delete();
    drive(1, 5'd6, 4'd1, 4'd1, 4'd1, 32'hD);
    step(); drive(1, 5'd7, 4'd2, 4'd2, 4'd2, 32'hE);
    step(); drive(1, 5'd8, 4'd3, 4'd3, 4'd3, 32'hF); flush = 1'b1;
    step(); flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("t5_occupancy", occupancy, 0);
    chk("t5_out_valid", out_valid, 0);
    // flush with occupancy 1 drops an otherwise acceptable input
    step(); drive(1, 5'd9, 4'd4, 4'd4, 4'd4, 32'h9);
    step(); drive(1, 5'd10, 4'd5, 4'd5, 4'd5, 32'h10); flush = 1'b1;
    step(); flush = 1'b0; in_valid = 1'b0;
    drain(4);
    chk("t5_none_delivered", dlog.size(), 0);

    // asynchronous reset mid-stream with one entry held
    drive(1, 5'd11, 4'd6, 4'd7, 4'd8, 32'h11);
    step(); in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("t6_out_valid", out_valid, 0);
    chk("t6_occupancy", occupancy, 0);
    chk("t6_in_ready", in_ready, 1);
    #4 rst_n = 1'b1;
    step(); drain(3);
    chk("t6_none_delivered", dlog.size(), 0);
    drive(1, 5'd27, 4'd5, 4'd6, 4'd1, 32'h27);
    step(); in_valid = 1'b0;
    @(negedge clk);
    chk("t6_new_head", opcode_out, 5'd27);
    chk("t6_new_s2", s2_out, 0);
    step(); drain(1);
    chk("t6_delivered", dlog.size() == 1 ? dlog[0] : 5'h1f, 5'd27);

    // streaming with simultaneous accept and deliver
    out_ready = 1'b1;
    drive(1, 5'd0,  4'd1, 4'd2, 4'd3, 32'h100);
    step(); drive(1, 5'd24, 4'd3, 4'd4, 4'd5, 32'h200);
    step(); drive(1, 5'd26, 4'd5, 4'd6, 4'd7, 32'h300);
    step(); drive(1, 5'd30, 4'd7, 4'd8, 4'd9, 32'h400);
    step(); drive(1, 5'd31, 4'd9, 4'd10, 4'd11, 32'h500);
    @(negedge clk);
    chk("t7_steady_occupancy", occupancy, 1);
    step(); in_valid = 1'b0;
    step(); step();
    out_ready = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
